// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyzer capture engine with a pre-trigger ring buffer,
// masked level/edge/Nth-occurrence triggering and oldest-first valid/ready readout.
module la_capture_core #(
    parameter int DATA_W   = 96,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sample_en_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              force_trig_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic              trig_edge_i,
    input  logic [15:0]       trig_count_i,
    output logic              armed_o,
    output logic              triggered_o,
    output logic              done_o,
    input  logic              rd_start_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              rd_last_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_DONE = 3'd4;
    localparam logic [AW-1:0] POST_N  = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] PRE_END = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] IDX_PEN = AW'(DEPTH - 2);

    logic [2:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rem, rd_addr, rd_idx, rd_raddr;
    logic [15:0]       occ, occ_nxt, tgt;
    logic              prev_match, force_pend, match, hit, in_wait, fire, wr_en, arm_ok, rd_go, rd_adv;

    assign armed_o = state == S_PRE || state == S_WAIT;
    assign done_o  = state == S_DONE;

    always_comb begin
        match    = ((data_i ^ trig_value_i) & trig_mask_i) == '0;
        hit      = trig_edge_i ? (match && !prev_match) : match;
        tgt      = trig_count_i == '0 ? 16'd1 : trig_count_i;
        occ_nxt  = &occ ? occ : occ + 16'd1;
        in_wait  = state == S_WAIT;
        // A pending force stores the following cycle unconditionally as the trigger sample
        fire     = in_wait && (force_pend || (sample_en_i && hit && occ_nxt >= tgt));
        wr_en    = (armed_o || state == S_POST) && (sample_en_i || (in_wait && force_pend));
        arm_ok   = arm_i && (state == S_IDLE || (done_o && !rd_valid_o));
        rd_go    = rd_start_i && done_o && !rd_valid_o && !arm_i;
        rd_adv   = rd_valid_o && rd_ready_i && !rd_last_o;
        rd_raddr = rd_go ? wptr : rd_addr + 1'b1;
    end

    always_ff @(posedge clk_i)
        if (wr_en) mem[wptr] <= data_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            wptr        <= '0;
            rem         <= '0;
            occ         <= '0;
            prev_match  <= 1'b0;
            force_pend  <= 1'b0;
            triggered_o <= 1'b0;
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            rd_last_o   <= 1'b0;
            rd_addr     <= '0;
            rd_idx      <= '0;
        end else if (abort_i) begin
            state       <= S_IDLE;
            force_pend  <= 1'b0;
            triggered_o <= 1'b0;
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            rd_last_o   <= 1'b0;
        end else begin
            force_pend <= in_wait && !fire && (force_pend || force_trig_i);
            if (fire || (in_wait && force_trig_i)) triggered_o <= 1'b1;
            if (arm_ok) begin
                state       <= PRE_TRIG == 0 ? S_WAIT : S_PRE;
                wptr        <= '0;
                occ         <= '0;
                prev_match  <= 1'b0;
                force_pend  <= 1'b0;
                triggered_o <= 1'b0;
            end else begin
                if (wr_en) wptr <= wptr + 1'b1;
                if (sample_en_i && armed_o) prev_match <= match;
                if (in_wait && sample_en_i && hit && !force_pend) occ <= occ_nxt;
                case (state)
                    S_PRE:   if (sample_en_i && wptr == PRE_END) state <= S_WAIT;
                    S_WAIT:  if (fire) begin
                        state <= POST_N == '0 ? S_DONE : S_POST;
                        rem   <= POST_N;
                    end
                    S_POST:  if (sample_en_i) begin
                        rem <= rem - 1'b1;
                        if (rem == AW'(1)) state <= S_DONE;
                    end
                    default: ;
                endcase
            end
            // Output register doubles as the synchronous RAM read port
            if (rd_go || rd_adv) begin
                rd_data_o  <= mem[rd_raddr];
                rd_addr    <= rd_raddr;
                rd_valid_o <= 1'b1;
                rd_idx     <= rd_go ? '0 : rd_idx + 1'b1;
                rd_last_o  <= !rd_go && rd_idx == IDX_PEN;
            end else if (rd_valid_o && rd_ready_i && rd_last_o) begin
                rd_valid_o <= 1'b0;
                rd_last_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: table-driven capture/readout vectors plus hand-written abort, reset and qualifier sequences.
module tb_la_capture_core;
    localparam int DW = 8, DEP = 16, PT = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] data = '0, mask = '0, value = '0, rd_data;
    logic          en = 1'b0, arm = 1'b0, abort = 1'b0, force_t = 1'b0, edge_m = 1'b0;
    logic [15:0]   count = '0;
    logic          armed, triggered, done, rd_start = 1'b0, rd_valid, rdy = 1'b0, rd_last;

    always #5 clk = ~clk;

    la_capture_core #(.DATA_W(DW), .DEPTH(DEP), .PRE_TRIG(PT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .sample_en_i(en), .arm_i(arm),
        .abort_i(abort), .force_trig_i(force_t), .trig_mask_i(mask), .trig_value_i(value),
        .trig_edge_i(edge_m), .trig_count_i(count), .armed_o(armed), .triggered_o(triggered),
        .done_o(done), .rd_start_i(rd_start), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_ready_i(rdy), .rd_last_o(rd_last)
    );

    typedef struct {
        logic [7:0]  mask, value;
        logic        edge_m;
        logic [15:0] count;
        bit          en_alt, dmode, rdy_alt;
        int          force_c, first_c, step;
    } vec_t;

    vec_t tbl [5];
    int   n_cmp = 0, n_bad = 0;
    int   c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] f(input int v, input bit dm);
        return dm ? {v[6:0], v[1]} : v[7:0];
    endfunction

    task automatic idle_chk(input string nm);
        chk({nm, "_armed"}, armed, 0);
        chk({nm, "_triggered"}, triggered, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rd_valid"}, rd_valid, 0);
        chk({nm, "_rd_last"}, rd_last, 0);
        chk({nm, "_rd_data"}, rd_data, 0);
    endtask

    task automatic capture(input int k);
        mask = tbl[k].mask; value = tbl[k].value; edge_m = tbl[k].edge_m; count = tbl[k].count;
        c = 0; data = f(0, tbl[k].dmode); en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_after_arm", armed, 1);
        c = 1;
        for (int g = 0; g < 200 && !done; g++) begin
            data = f(c, tbl[k].dmode);
            en = tbl[k].en_alt ? (c % 2 == 0) : 1'b1;
            force_t = c == tbl[k].force_c;
            if (force_t) chk("trig_before_force", triggered, 0);
            tick();
            force_t = 1'b0;
            if (tbl[k].force_c != 0 && c == tbl[k].force_c) chk("trig_after_force", triggered, 1);
            if (!done) c++;
        end
        en = 1'b0;
        chk("done", done, 1);
        chk("done_at_sample", c, tbl[k].first_c + 15 * tbl[k].step);
        chk("triggered_held", triggered, 1);
        chk("armed_in_done", armed, 0);
    endtask

    task automatic readout(input int k);
        int idx = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        if (!rd_valid) tick();
        chk("first_valid", rd_valid, 1);
        for (int g = 0; g < 100 && idx < 16; g++) begin
            rdy = tbl[k].rdy_alt ? (g % 2 == 0) : 1'b1;
            if (rd_valid) begin
                chk("rd_word", rd_data, f(tbl[k].first_c + idx * tbl[k].step, tbl[k].dmode));
                chk("rd_last", rd_last, idx == 15);
                if (rdy) idx++;
            end
            tick();
        end
        rdy = 1'b0;
        chk("word_count", idx, 16);
        chk("valid_after_last", rd_valid, 0);
        chk("done_after_read", done, 1);
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'h0A, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 0, 6, 1};
        tbl[1] = '{8'h01, 8'h01, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 0, 10, 1};
        tbl[2] = '{8'hFF, 8'h14, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 0, 12, 2};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 8, 5, 1};
        tbl[4] = '{8'hFF, 8'h0A, 1'b0, 16'd1, 1'b0, 1'b0, 1'b1, 0, 6, 1};

        #12;
        idle_chk("reset");
        rst_n = 1'b1;
        tick();
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        idle_chk("abort_with_arm");

        for (int k = 0; k < 5; k++) begin
            capture(k);
            readout(k);
        end

        // arm during an active readout is ignored, then abort ends it without rd_last
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_in_read_armed", armed, 0);
        chk("arm_in_read_done", done, 1);
        chk("arm_in_read_valid", rd_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0; rdy = 1'b0;
        idle_chk("abort_read");

        // abort part-way through POST
        mask = 8'hFF; value = 8'h0A; edge_m = 1'b0; count = 16'd1;
        c = 0; en = 1'b1; arm = 1'b1; data = 8'd0;
        tick();
        arm = 1'b0;
        for (int g = 0; g < 40 && !triggered; g++) begin
            c++; data = c[7:0];
            tick();
        end
        chk("post_triggered", triggered, 1);
        for (int g = 0; g < 3; g++) begin
            c++; data = c[7:0];
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; en = 1'b0;
        idle_chk("abort_post");

        // unqualified matches must not count toward the occurrence target
        mask = 8'hFF; value = 8'h55; count = 16'd2; data = 8'd0; en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int g = 0; g < 4; g++) tick();
        data = 8'h55; en = 1'b0;
        for (int g = 0; g < 10; g++) tick();
        chk("gated_hits_trig", triggered, 0);
        chk("gated_hits_armed", armed, 1);
        en = 1'b1;
        tick();
        chk("first_hit_trig", triggered, 0);
        tick();
        chk("second_hit_trig", triggered, 1);
        en = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_chk("abort_wait");

        // asynchronous reset in the middle of a readout
        capture(0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0; rdy = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        idle_chk("reset_read");
        rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        idle_chk("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
